// File: rtl/spi_counter_rx.sv
// SPI mode-0 slave that rebuilds counter words from the master board and
// echoes the previously received word back on miso.
module spi_counter_rx #(
   parameter int DATA_WIDTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sclk,
   input  logic                  mosi,
   input  logic                  cs_n,
   output logic                  miso,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  frame_err
);

   localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2,
      ERR   = 2'd3
   } state_e;

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic                   sclk_d1_q;
   logic                   cs_d1_q;
   logic [SYNC_STAGES:0]   live_q;

   state_e                 state_q;
   logic [CNT_W-1:0]       bit_cnt_q;
   logic [DATA_WIDTH-2:0]  shift_q;
   logic [DATA_WIDTH-1:0]  tx_q;
   logic [DATA_WIDTH-1:0]  echo_q;
   logic [DATA_WIDTH-1:0]  rx_data_q;
   logic                   rx_valid_q;
   logic                   frame_err_q;

   logic                   sclk_s;
   logic                   mosi_s;
   logic                   cs_s;
   logic                   sclk_rise;
   logic                   sclk_fall;
   logic                   cs_fall;
   logic                   cs_rise;
   logic [DATA_WIDTH-1:0]  shift_d;
   logic [DATA_WIDTH-1:0]  tx_d;
   logic [CNT_W-1:0]       bit_cnt_d;

   // NOTE: reset is synchronous, so it lives inside the clocked block and all
   // sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '1;
         sclk_d1_q   <= 1'b0;
         cs_d1_q     <= 1'b1;
         live_q      <= '0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
         sclk_d1_q   <= sclk_s;
         cs_d1_q     <= cs_s;
         live_q      <= {live_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d1_q;
   assign sclk_fall = ~sclk_s & sclk_d1_q;
   // cs edges only count once the whole chain holds real pin samples, so a
   // cs_n held low across reset is never mistaken for a new frame start.
   assign cs_fall   = live_q[SYNC_STAGES] & cs_d1_q & ~cs_s;
   assign cs_rise   = live_q[SYNC_STAGES] & ~cs_d1_q & cs_s;

   assign shift_d   = {shift_q, mosi_s};
   assign tx_d      = {tx_q[DATA_WIDTH-2:0], 1'b0};
   assign bit_cnt_d = (bit_cnt_q == FULL_CNT) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         tx_q        <= '0;
         echo_q      <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         if (cs_fall) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= echo_q;
         end else if (cs_rise) begin
            if (state_q == SHIFT && bit_cnt_q != FULL_CNT) begin
               frame_err_q <= 1'b1;
            end
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  tx_q <= echo_q;
               end
               SHIFT: begin
                  if (sclk_rise) begin
                     shift_q   <= shift_d[DATA_WIDTH-2:0];
                     bit_cnt_q <= bit_cnt_d;
                     if (bit_cnt_q == LAST_BIT) begin
                        rx_data_q  <= shift_d;
                        echo_q     <= shift_d;
                        rx_valid_q <= 1'b1;
                        state_q    <= DONE;
                     end
                  end else if (sclk_fall) begin
                     tx_q <= tx_d;
                  end
               end
               DONE: begin
                  if (sclk_rise) begin
                     frame_err_q <= 1'b1;
                     state_q     <= ERR;
                  end
               end
               ERR: begin
                  state_q <= ERR;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign miso      = tx_q[DATA_WIDTH-1];
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_counter_rx.sv
// Directed bench for spi_counter_rx: acts as an SPI mode-0 master at 6.25MHz
// and checks received words, echo data, pulses and latency.
`timescale 1ns/1ps
module tb_spi_counter_rx;

   localparam int DW = 16;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          sclk;
   logic          mosi;
   logic          cs_n;
   logic          miso;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          frame_err;

   int checks       = 0;
   int failures     = 0;
   int cyc          = 0;
   int valid_cnt    = 0;
   int err_cnt      = 0;
   int both_cnt     = 0;
   int valid_cyc    = 0;
   int last_rise_e1 = 0;
   int v0;
   int e0;
   logic [31:0] cap;

   spi_counter_rx #(
      .DATA_WIDTH (DW),
      .SYNC_STAGES(SS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .sclk     (sclk),
      .mosi     (mosi),
      .cs_n     (cs_n),
      .miso     (miso),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid) begin
         valid_cnt <= valid_cnt + 1;
         valid_cyc <= cyc;
      end
      if (frame_err) err_cnt <= err_cnt + 1;
      if (rx_valid && frame_err) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      wait_clk(8);
   endtask

   task automatic cs_high();
      wait_clk(8);
      cs_n = 1'b1;
      wait_clk(8);
   endtask

   // Master drives mosi while sclk is low and samples miso just before each rise.
   task automatic spi_bits(input logic [31:0] word, input int nbits, output logic [31:0] miso_cap);
      logic [31:0] c;
      c = '0;
      for (int i = nbits - 1; i >= 0; i--) begin
         mosi = word[i];
         wait_clk(8);
         c = {c[30:0], miso};
         sclk = 1'b1;
         last_rise_e1 = cyc + 1;
         wait_clk(8);
         sclk = 1'b0;
      end
      miso_cap = c;
   endtask

   initial begin
      reset = 1'b1;
      sclk  = 1'b0;
      mosi  = 1'b0;
      cs_n  = 1'b1;
      wait_clk(3);
      reset = 1'b0;
      wait_clk(1);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_miso", miso, 0);

      v0 = valid_cnt; e0 = err_cnt;
      wait_clk(200);
      check("idle_valid", valid_cnt - v0, 0);
      check("idle_err", err_cnt - e0, 0);

      // Frame 0x1234; echo is still the reset value.
      v0 = valid_cnt; e0 = err_cnt;
      cs_low();
      spi_bits(32'h1234, 16, cap);
      cs_high();
      check("f1234_valid", valid_cnt - v0, 1);
      check("f1234_err", err_cnt - e0, 0);
      check("f1234_data", rx_data, 32'h1234);
      check("f1234_miso", cap, 32'h0000);
      // Sampling edge is edge 1; the pulse is registered on edge SS+1.
      check("f1234_latency", valid_cyc - last_rise_e1, SS);

      // Back-to-back frames 0x00FF then 0xA5C3.
      v0 = valid_cnt; e0 = err_cnt;
      cs_low();
      spi_bits(32'h00FF, 16, cap);
      cs_high();
      check("f00ff_data", rx_data, 32'h00FF);
      check("f00ff_miso", cap, 32'h1234);
      cs_low();
      spi_bits(32'hA5C3, 16, cap);
      cs_high();
      check("fa5c3_data", rx_data, 32'hA5C3);
      check("fa5c3_miso", cap, 32'h00FF);
      check("b2b_valid", valid_cnt - v0, 2);
      check("b2b_err", err_cnt - e0, 0);

      // Short frame: 9 clocks then cs_n high.
      v0 = valid_cnt; e0 = err_cnt;
      cs_low();
      spi_bits(32'h0155, 9, cap);
      cs_high();
      check("short_err", err_cnt - e0, 1);
      check("short_valid", valid_cnt - v0, 0);
      check("short_data", rx_data, 32'hA5C3);
      check("short_miso", cap, 32'h014B);

      // Long frame: 0xFFFF followed by an extra 1.
      v0 = valid_cnt; e0 = err_cnt;
      cs_low();
      spi_bits(32'h1FFFF, 17, cap);
      cs_high();
      check("long_valid", valid_cnt - v0, 1);
      check("long_err", err_cnt - e0, 1);
      check("long_data", rx_data, 32'hFFFF);
      check("long_miso", cap >> 1, 32'hA5C3);

      v0 = valid_cnt; e0 = err_cnt;
      cs_low();
      spi_bits(32'h0001, 16, cap);
      cs_high();
      check("f0001_data", rx_data, 32'h0001);
      check("f0001_valid", valid_cnt - v0, 1);
      check("f0001_err", err_cnt - e0, 0);
      check("f0001_miso", cap, 32'hFFFF);

      // Reset for one clock after bit 8; master finishes the frame unaware.
      v0 = valid_cnt; e0 = err_cnt;
      cs_low();
      spi_bits(32'h12, 8, cap);
      wait_clk(2);
      reset = 1'b1;
      wait_clk(1);
      reset = 1'b0;
      wait_clk(4);
      check("midrst_data", rx_data, 0);
      check("midrst_miso", miso, 0);
      spi_bits(32'h34, 8, cap);
      cs_high();
      check("midrst_valid", valid_cnt - v0, 0);
      check("midrst_err", err_cnt - e0, 0);

      v0 = valid_cnt; e0 = err_cnt;
      cs_low();
      spi_bits(32'h270F, 16, cap);
      cs_high();
      check("f270f_data", rx_data, 32'h270F);
      check("f270f_valid", valid_cnt - v0, 1);
      check("f270f_miso", cap, 32'h0000);

      check("no_overlap", both_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
